// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding and sizing helpers for the divider
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Iteration counter width: must hold 0..2N for an N-bit operand divider
    function automatic int cnt_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/divider_div_step.sv
// rtl/divider_div_step.sv - one restoring shift-subtract iteration on magnitudes
module div_step #(
    parameter int N = 5
) (
    input  logic [N:0]     rem_i,
    input  logic [2*N-1:0] dvd_i,
    input  logic [N-1:0]   dsr_i,
    output logic [N:0]     rem_o,
    output logic [2*N-1:0] dvd_o
);

    logic [N+1:0] shifted;
    logic [N+1:0] trial;
    logic         qbit;

    // Shift the next dividend bit into the partial remainder, trial-subtract, restore on borrow
    always_comb begin
        shifted = {rem_i, dvd_i[2*N-1]};
        trial   = shifted - {2'b00, dsr_i};
        qbit    = ~trial[N+1];
        rem_o   = qbit ? trial[N:0] : shifted[N:0];
        dvd_o   = {dvd_i[2*N-2:0], qbit};
    end

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - sequential signed restoring divider, 2N-bit dividend by N-bit divisor
module divider
    import divider_pkg::*;
#(
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           ovf,
    output logic           dbz
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0]  LAST_CNT = CW'(2 * N - 1);
    localparam logic [2*N-1:0] POS_LIM  = (2 * N)'((2 ** (N - 1)) - 1);
    localparam logic [2*N-1:0] NEG_LIM  = (2 * N)'(2 ** (N - 1));

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N:0]     rem_q, rem_d;
    logic [2*N-1:0] dvd_q, dvd_d;
    logic [N-1:0]   dsr_q, dsr_d;
    logic           dsign_q, dsign_d;
    logic           qsign_q, qsign_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           ovf_q, ovf_d;
    logic           dbz_q, dbz_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   remo_q, remo_d;

    logic [N:0]     step_rem;
    logic [2*N-1:0] step_dvd;

    // dvd_q holds the dividend magnitude at first and fills with quotient bits from the right
    div_step #(.N(N)) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .dvd_o (step_dvd)
    );

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            dsign_q <= 1'b0;
            qsign_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            dsign_q <= dsign_d;
            qsign_q <= qsign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
        end
    end

    // Next state: capture magnitudes, iterate 2N times, then sign fix-up with saturation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        dsign_d = dsign_q;
        qsign_d = qsign_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        quo_d   = quo_q;
        remo_d  = remo_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend[2*N-1] ? ({(2*N){1'b0}} - dividend) : dividend;
                    dsr_d   = divisor[N-1] ? ({N{1'b0}} - divisor) : divisor;
                    dsign_d = dividend[2*N-1];
                    qsign_d = dividend[2*N-1] ^ divisor[N-1];
                    cnt_d   = '0;
                    rem_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (divisor == '0) ? FIN : CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (dsr_q == '0) begin
                    dbz_d  = 1'b1;
                    ovf_d  = 1'b0;
                    quo_d  = '0;
                    remo_d = '0;
                end else begin
                    dbz_d  = 1'b0;
                    // |r| < |divisor| <= 2^(N-1), so the low N bits carry the full magnitude
                    remo_d = dsign_q ? ({N{1'b0}} - rem_q[N-1:0]) : rem_q[N-1:0];
                    if (qsign_q) begin
                        if (dvd_q > NEG_LIM) begin
                            ovf_d = 1'b1;
                            quo_d = {1'b1, {(N-1){1'b0}}};
                        end else begin
                            ovf_d = 1'b0;
                            quo_d = {N{1'b0}} - dvd_q[N-1:0];
                        end
                    end else if (dvd_q > POS_LIM) begin
                        ovf_d = 1'b1;
                        quo_d = {1'b0, {(N-1){1'b1}}};
                    end else begin
                        ovf_d = 1'b0;
                        quo_d = dvd_q[N-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = remo_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - scoreboard bench for the signed sequential divider
module tb_divider;

    localparam int N = 5;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic signed [2*N-1:0] dividend = '0;
    logic signed [N-1:0]   divisor = '0;
    logic                  busy, done, ovf, dbz;
    logic signed [N-1:0]   quotient, remainder;

    typedef struct {
        string name;
        int    q;
        int    r;
        int    ov;
        int    dz;
        int    due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s quotient", e.name), int'(quotient), e.q);
                check($sformatf("%s remainder", e.name), int'(remainder), e.r);
                check($sformatf("%s ovf", e.name), int'(ovf), e.ov);
                check($sformatf("%s dbz", e.name), int'(dbz), e.dz);
                check($sformatf("%s latency", e.name), cyc, e.due);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("busy_timeout", 1, 0);
    endtask

    task automatic issue(input string name, input int dvd, input int dsr,
                         input int q, input int r, input int ov, input int dz);
        exp_t e;
        wait_idle();
        start    = 1'b1;
        dividend = (2*N)'(dvd);
        divisor  = N'(dsr);
        @(posedge clk);
        #1;
        e.name = name;
        e.q    = q;
        e.r    = r;
        e.ov   = ov;
        e.dz   = dz;
        e.due  = cyc + ((dsr == 0) ? 1 : 2 * N + 1);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check($sformatf("%s busy_after_accept", name), int'(busy), 1);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset quotient", int'(quotient), 0);
        check("reset remainder", int'(remainder), 0);
        check("reset ovf", int'(ovf), 0);
        check("reset dbz", int'(dbz), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, issued back-to-back so each start lands in the previous done cycle
        issue("100/7",     100,   7,  14,   2, 0, 0);
        issue("-100/7",   -100,   7, -14,  -2, 0, 0);
        issue("100/-16",   100, -16,  -6,   4, 0, 0);
        issue("-143/11",  -143,  11, -13,   0, 0, 0);
        issue("240/15",    240,  15,  15,   0, 1, 0);
        issue("-240/15",  -240,  15, -16,   0, 0, 0);
        issue("-512/-1",  -512,  -1,  15,   0, 1, 0);
        issue("-77/0",     -77,   0,   0,   0, 0, 1);
        issue("0/-7",        0,  -7,   0,   0, 0, 0);
        issue("511/-16",   511, -16, -16,  15, 1, 0);
        issue("-17/5",     -17,   5,  -3,  -2, 0, 0);
        issue("17/-5",      17,  -5,  -3,   2, 0, 0);
        issue("-16/1",     -16,   1, -16,   0, 0, 0);
        issue("16/1",       16,   1,  15,   0, 1, 0);

        // Start held high while operands churn: only the first request counts
        wait_idle();
        start    = 1'b1;
        dividend = (2*N)'(100);
        divisor  = N'(7);
        @(posedge clk);
        #1;
        e.name = "held";
        e.q    = 14;
        e.r    = 2;
        e.ov   = 0;
        e.dz   = 0;
        e.due  = cyc + 2 * N + 1;
        sb.push_back(e);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            dividend = (2*N)'(k * 37 - 200);
            divisor  = N'(k);
        end
        @(negedge clk);
        start = 1'b0;
        drain();

        // Reset in the middle of CALC: no done may follow, outputs clear
        start    = 1'b1;
        dividend = (2*N)'(-100);
        divisor  = N'(3);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset quotient", int'(quotient), 0);
        check("midreset remainder", int'(remainder), 0);
        check("midreset ovf", int'(ovf), 0);
        check("midreset dbz", int'(dbz), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);

        issue("post_reset 100/7", 100, 7, 14, 2, 0, 0);
        issue("post_reset -17/5", -17, 5, -3, -2, 0, 0);
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential signed divider: the inverse of the team's combinational signed multiplier.
- Takes a 2N-bit signed dividend (multiplier product width) and an N-bit signed divisor.
- Returns an N-bit signed quotient and an N-bit signed remainder, truncating toward zero.
- Restoring shift-subtract on magnitudes, one quotient bit per clock. Start/done handshake to the datapath controller.

Parameters:
- N, 5, operand width. Dividend is 2N bits; divisor, quotient and remainder are N bits each.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  2N  signed dividend; captured when start is accepted
- divisor  input  N  signed divisor; captured when start is accepted
- busy  output  1  high from the accept edge until the done edge
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  N  signed quotient, held until the next done
- remainder  output  N  signed remainder, held until the next done
- ovf  output  1  quotient did not fit in N bits; held with results
- dbz  output  1  divisor was zero; held with results

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, ovf, dbz = 0; quotient, remainder = 0; internal registers cleared. An operation in flight is abandoned and no done is produced.
- States: IDLE, CALC, FIN.
- IDLE, start=1 at edge E0: capture |dividend| (2N-bit unsigned), |divisor| (N-bit unsigned), the sign of the dividend, and the quotient sign = sign(dividend) XOR sign(divisor).
  - Set busy=1. Clear the iteration counter and the partial remainder.
  - Next state is CALC, or FIN if divisor == 0.
- CALC, edges E1..E2N, one iteration per edge:
  - Shift {partial remainder (N+1 bits), dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
  - After the 2N-th iteration, go to FIN.
- FIN, one edge (E2N+1):
  - Apply signs: quotient negated if the quotient sign is 1; remainder negated if the dividend sign is 1.
  - Overflow rule: the positive limit is 2^(N-1)-1 and the negative limit is 2^(N-1), applied to the magnitude. If the magnitude exceeds the limit, set ovf=1 and saturate the quotient to 2^(N-1)-1 or -2^(N-1). The remainder is still the true remainder; it always fits because |r| < |divisor| <= 2^(N-1).
  - Divide by zero: dbz=1, quotient=0, remainder=0, ovf=0.
  - Register the outputs, assert done=1, drop busy, return to IDLE.
- Latency: done is high in the cycle after edge E2N+1, i.e. 2N+1 edges after accept (11 for N=5). Divide-by-zero takes 1 edge after accept.
- Throughput: a start in the same cycle that done is high is accepted. Back-to-back operations cost 2N+2 edges each.
- start while busy is ignored, and captured operands are unaffected.
- ovf and dbz update only with done.
- Zero dividend: quotient=0, remainder=0, no sign artefacts (no -0 issue in two's complement).

Decomposition:
- Shared package: state encoding (IDLE, CALC, FIN) and the counter width ($clog2(2N+1)).
- One natural sub-module: div_step. It is combinational and does one restoring iteration: shift, trial subtract, quotient bit, next partial remainder.
- The top level keeps the FSM, counter, operand registers and sign/saturation fix-up.

Test Plan (N=5):
- Positive operands: dividend=100, divisor=7, start one cycle -> busy high for 11 edges, then done pulse; quotient=14, remainder=2, ovf=0, dbz=0.
- Sign combinations: -100/7 -> q=-14, r=-2. 100/-16 -> q=-6, r=4. -143/11 (multiplier round trip, -13*11) -> q=-13, r=0.
- Overflow: 240/15 -> ovf=1, q=15 (saturated), r=0. -240/15 -> q=-16, ovf=0. -512/-1 -> ovf=1, q=15.
- Divide by zero: any dividend/0 -> done one edge after accept; dbz=1, q=0, r=0.
- Handshake:
  - start held high through an operation with changing operands -> only the first is computed and results match it.
  - start in the done cycle -> second operation accepted, done again 11 edges later.
- Reset mid-CALC: assert rst at edge E5, deassert -> all outputs 0, no done pulse, next start computes correctly.
